button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Front-end stage for the colour-code lock.
- Takes four raw, asynchronous, bouncy push-buttons (Start, Red, Green, Blue) and synchronises and debounces each one.
- Emits clean single-cycle, mutually exclusive press pulses on Start/Red/Green/Blue, which feed the code detector directly.
- Simultaneous multi-button presses are rejected and flagged on Conflict.

Parameters:
- SYNC_STAGES, 2, flip-flop stages per button synchroniser (minimum 2).
- DEBOUNCE_CYCLES, 4, consecutive identical samples needed to accept a level change (minimum 1; set large, e.g. 500000, on hardware).

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  synchronous, active-high reset.
- BtnStart  input  1  raw Start button, asynchronous, active-high.
- BtnRed  input  1  raw Red button, asynchronous, active-high.
- BtnGreen  input  1  raw Green button, asynchronous, active-high.
- BtnBlue  input  1  raw Blue button, asynchronous, active-high.
- Start  output  1  one-cycle press pulse, registered.
- Red  output  1  one-cycle press pulse, registered.
- Green  output  1  one-cycle press pulse, registered.
- Blue  output  1  one-cycle press pulse, registered.
- Conflict  output  1  one-cycle pulse: a multi-button press was rejected, registered.

Behaviour:
- One clock (Clk). Reset is synchronous and active-high on Rst.
- Reset clears all synchroniser flops, debounced levels, debounce counters and pulse outputs to 0, and sets the FSM to S_Idle.
- Synchroniser: per button, a SYNC_STAGES-deep flop chain; the last stage is sync[i].
- Debounce, per button:
  - Keeps a debounced level deb[i] and a counter cnt[i] sized to hold DEBOUNCE_CYCLES-1.
  - Each edge where sync[i] == deb[i]: cnt[i] <= 0.
  - Each edge where sync[i] != deb[i] and cnt[i] == DEBOUNCE_CYCLES-1: deb[i] <= sync[i], cnt[i] <= 0.
  - Otherwise cnt[i] increments.
  - Any bounce back to the old level restarts the count. Presses and releases are filtered identically.
- FSM, two states, evaluated on the deb vector:
  - S_Idle, exactly one deb bit high: assert the matching output for one cycle, go to S_Held.
  - S_Idle, two or more deb bits high on the same edge: assert Conflict for one cycle, no colour/Start pulse, go to S_Held.
  - S_Idle, no deb bit high: stay, all outputs 0.
  - S_Held: all outputs 0. Stay until every deb bit is 0, then go to S_Idle.
  - Extra buttons pressed while in S_Held are ignored and produce no pulse and no Conflict.
- Output guarantees:
  - At most one of Start/Red/Green/Blue/Conflict is high in any cycle.
  - Each pulse is exactly 1 cycle wide.
  - Between two pulses there is at least one cycle with all buttons debounced-released.
- Latency:
  - Count clock edges, with edge 1 being the first edge that samples the raw input at its new, stable level.
  - The pulse is high after edge SYNC_STAGES+DEBOUNCE_CYCLES+1 (7 with defaults) and low after the following edge.
- Holding a button longer produces no repeat pulse.
- Reset mid-operation:
  - Any pulse in flight is dropped.
  - A button still physically held after Rst deasserts is debounced as a fresh press and produces one pulse at the normal latency.
- Rst held high: all outputs stay 0 regardless of buttons.

Test Plan:
- Reset, then hold BtnRed=1 (clean) from edge 1 → Red=1 only after edge 7, 0 after edge 8; no further pulse while held.
- BtnBlue bounces 1,0,1,0 (one cycle each), then stays 1 → no pulse during the bounce; one Blue pulse 7 edges after the last 0→1 transition.
- BtnGreen and BtnRed rise on the same cycle → Conflict=1 for one cycle, Red=Green=0. After both are released and BtnGreen is pressed alone → one Green pulse.
- BtnStart held, then BtnRed pressed while Start is still held → one Start pulse only. After release of both and a fresh BtnRed press → Red pulse.
- Sequence Start, Red, Blue, Green, Red, each held 10 cycles with 10 released cycles between → exactly five pulses in order, each 1 cycle wide, no overlap.
- BtnRed held, Rst=1 for 3 cycles mid-hold, then Rst=0 with BtnRed still 1 → outputs 0 during reset; one Red pulse 7 edges after Rst deasserts.

Source files
------------

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Front end of the colour-code lock. It turns four raw, asynchronous,
// bouncy push-buttons into clean, single-cycle, mutually exclusive press
// pulses. If more than one button becomes debounced-pressed on the same
// edge, the press is rejected and reported on Conflict instead.
//
// Parameters:
//   SYNC_STAGES      flip-flops per button synchroniser (>= 2)
//   DEBOUNCE_CYCLES  consecutive identical samples needed to accept a
//                    level change (>= 1)
//
// Ports:
//   Clk       in   system clock, rising edge
//   Rst       in   synchronous, active-high reset
//   BtnStart  in   raw Start button (async, active-high)
//   BtnRed    in   raw Red button   (async, active-high)
//   BtnGreen  in   raw Green button (async, active-high)
//   BtnBlue   in   raw Blue button  (async, active-high)
//   Start     out  one-cycle press pulse, registered
//   Red       out  one-cycle press pulse, registered
//   Green     out  one-cycle press pulse, registered
//   Blue      out  one-cycle press pulse, registered
//   Conflict  out  one-cycle pulse: a multi-button press was rejected
//
// Latency: a clean press is first sampled on edge 1; the pulse is high
// after edge SYNC_STAGES+DEBOUNCE_CYCLES+1 and low after the next edge.
// ---------------------------------------------------------------------------
module button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic BtnStart,
  input  logic BtnRed,
  input  logic BtnGreen,
  input  logic BtnBlue,
  output logic Start,
  output logic Red,
  output logic Green,
  output logic Blue,
  output logic Conflict
);

  localparam int NUM_BTN = 4;
  localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    S_Idle,
    S_Held
  } state_t;

  // Bit order used for every per-button vector: 0 Start, 1 Red, 2 Green, 3 Blue.
  logic [NUM_BTN-1:0] raw;
  assign raw = {BtnBlue, BtnGreen, BtnRed, BtnStart};

  // ---- Stage p0: synchronisers ------------------------------------------
  logic [SYNC_STAGES-1:0] sync_chain_p0 [NUM_BTN];
  logic [NUM_BTN-1:0]     sync_p0;

  always_ff @(posedge Clk) begin
    for (int i = 0; i < NUM_BTN; i++) begin
      if (Rst) begin
        sync_chain_p0[i] <= '0;
      end else begin
        sync_chain_p0[i] <= {sync_chain_p0[i][SYNC_STAGES-2:0], raw[i]};
      end
    end
  end

  always_comb begin
    sync_p0 = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      sync_p0[i] = sync_chain_p0[i][SYNC_STAGES-1];
    end
  end

  // ---- Stage p1: debounce -----------------------------------------------
  // A level change is accepted only after the synchronised input has
  // differed from the debounced level for DEBOUNCE_CYCLES consecutive
  // edges; any return to the old level restarts the count.
  logic [NUM_BTN-1:0] deb_p1;
  logic [CNT_W-1:0]   cnt_p1 [NUM_BTN];

  always_ff @(posedge Clk) begin
    for (int i = 0; i < NUM_BTN; i++) begin
      if (Rst) begin
        deb_p1[i] <= 1'b0;
        cnt_p1[i] <= '0;
      end else if (sync_p0[i] == deb_p1[i]) begin
        cnt_p1[i] <= '0;
      end else if (cnt_p1[i] == CNT_MAX) begin
        deb_p1[i] <= sync_p0[i];
        cnt_p1[i] <= '0;
      end else begin
        cnt_p1[i] <= cnt_p1[i] + 1'b1;
      end
    end
  end

  // More than one bit set: clearing the lowest set bit leaves something.
  logic multi_p1;
  assign multi_p1 = |(deb_p1 & (deb_p1 - 4'd1));

  // ---- Stage p2: press FSM and registered pulses ------------------------
  state_t state_p2;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_p2 <= S_Idle;
      Start    <= 1'b0;
      Red      <= 1'b0;
      Green    <= 1'b0;
      Blue     <= 1'b0;
      Conflict <= 1'b0;
    end else begin
      Start    <= 1'b0;
      Red      <= 1'b0;
      Green    <= 1'b0;
      Blue     <= 1'b0;
      Conflict <= 1'b0;
      case (state_p2)
        S_Idle: begin
          if (deb_p1 != '0) begin
            state_p2 <= S_Held;
            if (multi_p1) begin
              Conflict <= 1'b1;
            end else begin
              Start <= deb_p1[0];
              Red   <= deb_p1[1];
              Green <= deb_p1[2];
              Blue  <= deb_p1[3];
            end
          end
        end
        // Wait for a full debounced release so a held button, or one added
        // while another is held, never produces a second pulse.
        S_Held: begin
          if (deb_p1 == '0) begin
            state_p2 <= S_Idle;
          end
        end
        default: state_p2 <= S_Idle;
      endcase
    end
  end

endmodule
